// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two small FIFOs (ALU path A, load path B)
// drained round-robin into one registered write port, plus a RAW scoreboard.
module rf_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_rw,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_rw,
  input  logic [DW-1:0] b_data,
  output logic          WrEn,
  output logic [AW-1:0] Rw,
  output logic [DW-1:0] busW,
  input  logic [AW-1:0] qa,
  input  logic [AW-1:0] qb,
  output logic          qa_pend,
  output logic          qb_pend
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] rw_mem_q [2][DEPTH];
  logic [AW-1:0] rw_mem_d [2][DEPTH];
  logic [DW-1:0] dat_mem_q [2][DEPTH];
  logic [DW-1:0] dat_mem_d [2][DEPTH];
  logic [PW-1:0] head_q [2];
  logic [PW-1:0] head_d [2];
  logic [PW-1:0] tail_q [2];
  logic [PW-1:0] tail_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  // rr_q = 1 means B is favoured on the next contended grant
  logic          rr_q, rr_d;
  logic          wren_q, wren_d;
  logic [AW-1:0] rw_q, rw_d;
  logic [DW-1:0] busw_q, busw_d;

  logic [1:0]    in_valid;
  logic [AW-1:0] in_rw [2];
  logic [DW-1:0] in_data [2];
  logic [1:0]    rdy;
  logic [1:0]    push;
  logic [1:0]    grant;
  logic [1:0]    nonempty;
  logic [AW-1:0] head_rw [2];
  logic [DW-1:0] head_dat [2];
  logic          qa_hit, qb_hit;
  logic [PW-1:0] idx;

  assign in_valid   = {b_valid, a_valid};
  assign in_rw[0]   = a_rw;
  assign in_rw[1]   = b_rw;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      nonempty[r] = cnt_q[r] != '0;
      rdy[r]      = Rst_n && (cnt_q[r] != CW'(DEPTH));
      push[r]     = in_valid[r] && rdy[r] && (in_rw[r] != '0);
      head_rw[r]  = rw_mem_q[r][head_q[r]];
      head_dat[r] = dat_mem_q[r][head_q[r]];
    end

    // equal destinations: A is older, so it must land first
    grant[0] = nonempty[0] &&
               (!nonempty[1] || (head_rw[0] == head_rw[1]) || !rr_q);
    grant[1] = nonempty[1] && !grant[0];

    rr_d = rr_q;
    if (&nonempty) rr_d = grant[0];

    wren_d = |grant;
    rw_d   = rw_q;
    busw_d = busw_q;
    if (grant[0]) begin
      rw_d   = head_rw[0];
      busw_d = head_dat[0];
    end else if (grant[1]) begin
      rw_d   = head_rw[1];
      busw_d = head_dat[1];
    end

    rw_mem_d  = rw_mem_q;
    dat_mem_d = dat_mem_q;
    for (int r = 0; r < 2; r++) begin
      head_d[r] = head_q[r] + PW'(grant[r]);
      tail_d[r] = tail_q[r] + PW'(push[r]);
      cnt_d[r]  = cnt_q[r] + CW'(push[r]) - CW'(grant[r]);
      if (push[r]) begin
        rw_mem_d[r][tail_q[r]]  = in_rw[r];
        dat_mem_d[r][tail_q[r]] = in_data[r];
      end
    end

    qa_hit = 1'b0;
    qb_hit = 1'b0;
    idx    = '0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_q[r] + PW'(k);
        if (CW'(k) < cnt_q[r]) begin
          if (rw_mem_q[r][idx] == qa) qa_hit = 1'b1;
          if (rw_mem_q[r][idx] == qb) qb_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int r = 0; r < 2; r++) begin
        head_q[r] <= '0;
        tail_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      rr_q   <= 1'b0;
      wren_q <= 1'b0;
      rw_q   <= '0;
      busw_q <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        head_q[r] <= head_d[r];
        tail_q[r] <= tail_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      rr_q   <= rr_d;
      wren_q <= wren_d;
      rw_q   <= rw_d;
      busw_q <= busw_d;
    end
  end

  // payload storage needs no reset; occupancy comes from cnt_q
  always_ff @(posedge Clk) begin
    rw_mem_q  <= rw_mem_d;
    dat_mem_q <= dat_mem_d;
  end

  assign a_ready = rdy[0];
  assign b_ready = rdy[1];
  assign WrEn    = wren_q;
  assign Rw      = rw_q;
  assign busW    = busw_q;
  assign qa_pend = (qa != '0) && (qa_hit || (wren_q && (rw_q == qa)));
  assign qb_pend = (qb != '0) && (qb_hit || (wren_q && (rw_q == qb)));

endmodule
